// File: rtl/pulse_train_gen.sv
// pulse_train_gen
// Multi-channel pulse-train generator. Each channel turns a start strobe into
// a train of pulses with programmable initial delay, high width, period and
// pulse count (count 0 = continuous until stopped). All channels share one
// clock and are otherwise fully independent.
//
// Ports
//   clk         clock
//   rst         asynchronous active-high reset, clears all state
//   start_evt   per-channel start strobe
//   stop_evt    per-channel abort strobe (wins over start)
//   cfg_delay   per-channel cycles from start to first rising edge
//   cfg_width   per-channel high time (0 behaves as 1)
//   cfg_period  per-channel rising-to-rising time (<= width gives 1-cycle gap)
//   cfg_count   per-channel pulses per train (0 = continuous)
//   pulse_out   registered pulse outputs
//   busy        channel is not idle
//   done        one-cycle strobe after the last high cycle of a finite train
module pulse_train_gen #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 32,
    parameter int NUM_W  = 16,
    parameter int RETRIG = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CH_NUM-1:0]         start_evt,
    input  logic [CH_NUM-1:0]         stop_evt,
    input  logic [CH_NUM*CNT_W-1:0]   cfg_delay,
    input  logic [CH_NUM*CNT_W-1:0]   cfg_width,
    input  logic [CH_NUM*CNT_W-1:0]   cfg_period,
    input  logic [CH_NUM*NUM_W-1:0]   cfg_count,
    output logic [CH_NUM-1:0]         pulse_out,
    output logic [CH_NUM-1:0]         busy,
    output logic [CH_NUM-1:0]         done
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        HIGH,
        LOW
    } state_t;

    localparam bit RETRIG_EN = (RETRIG != 0);

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        state_t             state, state_nxt;
        logic [CNT_W-1:0]   cnt, cnt_nxt;
        logic [NUM_W-1:0]   pcnt, pcnt_nxt;
        logic               done_nxt;
        logic               load;

        // Shadow configuration, stored pre-decremented so that every phase
        // ends on an equality compare and the full CNT_W range is usable.
        logic [CNT_W-1:0]   sh_dm1, sh_wm1, sh_lm1;
        logic [NUM_W-1:0]   sh_nm1;
        logic               sh_cont;

        logic [CNT_W-1:0]   c_d, c_w, c_p, w_eff, low_m1;
        logic [NUM_W-1:0]   c_n;

        logic               pulse_q, busy_q, done_q;

        assign c_d   = cfg_delay [g*CNT_W +: CNT_W];
        assign c_w   = cfg_width [g*CNT_W +: CNT_W];
        assign c_p   = cfg_period[g*CNT_W +: CNT_W];
        assign c_n   = cfg_count [g*NUM_W +: NUM_W];
        assign w_eff = (c_w == '0) ? CNT_W'(1) : c_w;
        // Low time minus one: period-width when period exceeds width, else 1.
        assign low_m1 = (c_p > w_eff) ? (c_p - w_eff - CNT_W'(1)) : '0;

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            pcnt_nxt  = pcnt;
            done_nxt  = 1'b0;
            load      = 1'b0;
            if (stop_evt[g]) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                pcnt_nxt  = '0;
            end else if (start_evt[g] && (state == IDLE || RETRIG_EN)) begin
                load      = 1'b1;
                cnt_nxt   = '0;
                pcnt_nxt  = '0;
                state_nxt = (c_d != '0) ? DELAY : HIGH;
            end else begin
                case (state)
                    DELAY: begin
                        if (cnt == sh_dm1) begin
                            state_nxt = HIGH;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (cnt == sh_wm1) begin
                            cnt_nxt = '0;
                            if (!sh_cont && pcnt == sh_nm1) begin
                                state_nxt = IDLE;
                                pcnt_nxt  = '0;
                                done_nxt  = 1'b1;
                            end else begin
                                state_nxt = LOW;
                                // Saturates in continuous mode; never compared there.
                                if (pcnt != '1) pcnt_nxt = pcnt + NUM_W'(1);
                            end
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                    LOW: begin
                        if (cnt == sh_lm1) begin
                            state_nxt = HIGH;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state   <= IDLE;
                cnt     <= '0;
                pcnt    <= '0;
                sh_dm1  <= '0;
                sh_wm1  <= '0;
                sh_lm1  <= '0;
                sh_nm1  <= '0;
                sh_cont <= 1'b0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                pcnt  <= pcnt_nxt;
                if (load) begin
                    sh_dm1  <= c_d - CNT_W'(1);
                    sh_wm1  <= w_eff - CNT_W'(1);
                    sh_lm1  <= low_m1;
                    sh_nm1  <= c_n - NUM_W'(1);
                    sh_cont <= (c_n == '0);
                end
                // Outputs are registered copies of the next state so they
                // line up exactly with the state they describe.
                pulse_q <= (state_nxt == HIGH);
                busy_q  <= (state_nxt != IDLE);
                done_q  <= done_nxt;
            end
        end

        assign pulse_out[g] = pulse_q;
        assign busy[g]      = busy_q;
        assign done[g]      = done_q;
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Testbench for pulse_train_gen: two instances (start-while-busy ignored and
// retriggerable) share all stimulus and are compared every cycle against a
// waveform model computed from each train's start time and configuration.
module tb_pulse_train_gen;
    localparam int CH = 4;
    localparam int CW = 8;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CH-1:0]    start_evt = '0;
    logic [CH-1:0]    stop_evt  = '0;
    logic [CH*CW-1:0] cfg_delay  = '0;
    logic [CH*CW-1:0] cfg_width  = '0;
    logic [CH*CW-1:0] cfg_period = '0;
    logic [CH*NW-1:0] cfg_count  = '0;
    logic [CH-1:0]    po [2];
    logic [CH-1:0]    bz [2];
    logic [CH-1:0]    dn [2];

    pulse_train_gen #(.CH_NUM(CH), .CNT_W(CW), .NUM_W(NW), .RETRIG(0)) dut0 (
        .clk(clk), .rst(rst), .start_evt(start_evt), .stop_evt(stop_evt),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period),
        .cfg_count(cfg_count), .pulse_out(po[0]), .busy(bz[0]), .done(dn[0])
    );

    pulse_train_gen #(.CH_NUM(CH), .CNT_W(CW), .NUM_W(NW), .RETRIG(1)) dut1 (
        .clk(clk), .rst(rst), .start_evt(start_evt), .stop_evt(stop_evt),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_period(cfg_period),
        .cfg_count(cfg_count), .pulse_out(po[1]), .busy(bz[1]), .done(dn[1])
    );

    initial forever #5 clk = ~clk;

    // Model state per instance/channel: active train start edge and
    // effective delay, width, period and count.
    bit act [2][CH];
    int t0  [2][CH];
    int md  [2][CH];
    int mw  [2][CH];
    int mp  [2][CH];
    int mn  [2][CH];
    int e = 0;
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected outputs sampled just after edge ed.
    function automatic void eval(input int i, input int c, input int ed,
                                 output logic p, output logic b, output logic d);
        int j, last;
        p = 1'b0; b = 1'b0; d = 1'b0;
        if (!act[i][c]) return;
        j = ed - t0[i][c] - md[i][c];   // cycles since first rising edge
        if (j < 0) begin
            b = 1'b1;
            return;
        end
        if (mn[i][c] != 0) begin
            last = (mn[i][c] - 1) * mp[i][c] + mw[i][c] - 1;
            if (j > last) begin
                d = (j == last + 1);
                return;
            end
        end
        b = 1'b1;
        p = ((j % mp[i][c]) < mw[i][c]);
    endfunction

    task automatic set_cfg(input int c, input int d, input int w, input int p, input int n);
        cfg_delay [c*CW +: CW] = CW'(d);
        cfg_width [c*CW +: CW] = CW'(w);
        cfg_period[c*CW +: CW] = CW'(p);
        cfg_count [c*NW +: NW] = NW'(n);
    endtask

    task automatic tick();
        logic p, b, d;
        logic [CH-1:0] ep, eb, ed;
        int w, pr;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < CH; c++) begin
                eval(i, c, e - 1, p, b, d);
                if (rst || stop_evt[c]) begin
                    act[i][c] = 1'b0;
                end else if (start_evt[c] && (!b || i == 1)) begin
                    act[i][c] = 1'b1;
                    t0[i][c]  = e;
                    md[i][c]  = int'(cfg_delay[c*CW +: CW]);
                    w         = int'(cfg_width[c*CW +: CW]);
                    pr        = int'(cfg_period[c*CW +: CW]);
                    mw[i][c]  = (w == 0) ? 1 : w;
                    mp[i][c]  = (pr > mw[i][c]) ? pr : mw[i][c] + 1;
                    mn[i][c]  = int'(cfg_count[c*NW +: NW]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < CH; c++) begin
                eval(i, c, e, p, b, d);
                ep[c] = p; eb[c] = b; ed[c] = d;
            end
            chk($sformatf("dut%0d pulse_out edge %0d", i, e), 32'(po[i]), 32'(ep));
            chk($sformatf("dut%0d busy edge %0d", i, e), 32'(bz[i]), 32'(eb));
            chk($sformatf("dut%0d done edge %0d", i, e), 32'(dn[i]), 32'(ed));
        end
        e++;
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < CH; c++)
                act[i][c] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d async rst pulse_out", i), 32'(po[i]), 32'd0);
            chk($sformatf("dut%0d async rst busy", i), 32'(bz[i]), 32'd0);
            chk($sformatf("dut%0d async rst done", i), 32'(dn[i]), 32'd0);
        end
    endtask

    // Hand-derived waveforms (bit k-1 = sample k cycles after the start edge).
    logic [9:0] p0pat = 10'b0011100111;
    logic [9:0] b0pat = 10'b0011111111;
    logic [9:0] d0pat = 10'b0100000000;
    logic [9:0] p1pat = 10'b0000010000;
    logic [9:0] b1pat = 10'b0000011111;
    logic [9:0] d1pat = 10'b0000100000;

    initial begin
        // Reset state.
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d reset pulse_out", i), 32'(po[i]), 32'd0);
            chk($sformatf("dut%0d reset busy", i), 32'(bz[i]), 32'd0);
            chk($sformatf("dut%0d reset done", i), 32'(dn[i]), 32'd0);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Ch0: D=0 W=3 P=5 N=2; Ch1: D=4 W=0 N=1.
        set_cfg(0, 0, 3, 5, 2);
        set_cfg(1, 4, 0, 0, 1);
        start_evt = 4'b0011;
        for (int k = 1; k <= 10; k++) begin
            tick();
            start_evt = '0;
            for (int i = 0; i < 2; i++) begin
                chk("ch0 pulse pattern", 32'(po[i][0]), 32'(p0pat[k-1]));
                chk("ch0 busy pattern",  32'(bz[i][0]), 32'(b0pat[k-1]));
                chk("ch0 done pattern",  32'(dn[i][0]), 32'(d0pat[k-1]));
                chk("ch1 pulse pattern", 32'(po[i][1]), 32'(p1pat[k-1]));
                chk("ch1 busy pattern",  32'(bz[i][1]), 32'(b1pat[k-1]));
                chk("ch1 done pattern",  32'(dn[i][1]), 32'(d1pat[k-1]));
            end
        end

        // Ch2 continuous W=4 P=2, then stop, then simultaneous start+stop.
        set_cfg(2, 0, 4, 2, 0);
        start_evt[2] = 1'b1;
        tick();
        start_evt[2] = 1'b0;
        repeat (14) tick();
        stop_evt[2] = 1'b1;
        tick();
        stop_evt[2] = 1'b0;
        for (int i = 0; i < 2; i++)
            chk("ch2 stop pulse_out", 32'(po[i][2]), 32'd0);
        repeat (3) tick();
        start_evt[2] = 1'b1;
        stop_evt[2]  = 1'b1;
        tick();
        start_evt[2] = 1'b0;
        stop_evt[2]  = 1'b0;
        for (int i = 0; i < 2; i++)
            chk("ch2 start+stop busy", 32'(bz[i][2]), 32'd0);
        repeat (3) tick();

        // Ch3: start again mid-HIGH with new D=2 W=2.
        set_cfg(3, 0, 6, 8, 1);
        start_evt[3] = 1'b1;
        tick();
        start_evt[3] = 1'b0;
        tick();
        tick();
        set_cfg(3, 2, 2, 0, 1);
        start_evt[3] = 1'b1;
        tick();
        start_evt[3] = 1'b0;
        chk("retrig0 keeps pulse", 32'(po[0][3]), 32'd1);
        chk("retrig1 low gap", 32'(po[1][3]), 32'd0);
        repeat (10) tick();

        // Full counter range with cfg churn during the train.
        set_cfg(1, 255, 255, 0, 2);
        start_evt[1] = 1'b1;
        tick();
        start_evt[1] = 1'b0;
        repeat (770) begin
            cfg_delay  = $urandom;
            cfg_width  = $urandom;
            cfg_period = $urandom;
            cfg_count  = 16'($urandom);
            tick();
        end

        // Reset during DELAY (ch0) and HIGH (ch1).
        set_cfg(0, 6, 2, 3, 1);
        set_cfg(1, 0, 8, 9, 1);
        start_evt = 4'b0011;
        tick();
        start_evt = '0;
        repeat (2) tick();
        async_reset();
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // Randomised independent channels, cfg changing every cycle.
        repeat (500) begin
            for (int c = 0; c < CH; c++) begin
                set_cfg(c, $urandom_range(0, 5), $urandom_range(0, 5),
                        $urandom_range(0, 9), $urandom_range(0, 3));
                start_evt[c] = ($urandom_range(0, 7) == 0);
                stop_evt[c]  = ($urandom_range(0, 39) == 0);
            end
            tick();
            if (rst) rst = 1'b0;
            if ($urandom_range(0, 149) == 0) async_reset();
        end
        start_evt = '0;
        stop_evt  = '0;
        rst = 1'b0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Multi-channel, parametrised pulse generator. Each channel runs its own state machine and turns a start event into a train of pulses with programmable initial delay, high width, period and pulse count, including continuous mode. It is the successor to the single-channel fixed pulse generator and sits in the same timing/trigger fabric. It drives strobes, gates and test patterns from one clock domain.

## Interface
Parameters:
- CH_NUM, 4, number of independent channels (1..32)
- CNT_W, 32, width of delay/width/period counters
- NUM_W, 16, width of pulse-count field
- RETRIG, 0, 1 = start while busy restarts the channel; 0 = start while busy is ignored

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset; all state cleared immediately
- start_evt  input  CH_NUM  per-channel start strobe, sampled each clk
- stop_evt  input  CH_NUM  per-channel abort strobe
- cfg_delay  input  CH_NUM*CNT_W  cycles from start to first rising edge, channel i at [i*CNT_W +: CNT_W]
- cfg_width  input  CH_NUM*CNT_W  high time in cycles; 0 treated as 1
- cfg_period  input  CH_NUM*CNT_W  rising-to-rising cycles; values <= width give a 1-cycle low gap
- cfg_count  input  CH_NUM*NUM_W  pulses per train; 0 = continuous until stop
- pulse_out  output  CH_NUM  generated pulses, registered
- busy  output  CH_NUM  channel not IDLE
- done  output  CH_NUM  1-cycle strobe at natural end of a train

## Operation
- Per-channel FSM states: IDLE, DELAY, HIGH, LOW. Channels are fully independent.
- Config is latched into shadow registers on an accepted start. Changes to cfg_* during a train have no effect until the next accepted start.
- Transitions:
  - IDLE + start: go to DELAY if delay > 0, else HIGH.
  - DELAY: go to HIGH after delay cycles.
  - HIGH: after eff_width cycles (eff_width = max(width,1)), increment the pulse counter. If the count is reached (count != 0), go to IDLE and assert done. Otherwise go to LOW.
  - LOW: after eff_low cycles, go to HIGH. eff_low = period - eff_width if period > eff_width, else 1.
- No trailing LOW phase after the last pulse.
- Priority per channel: rst > stop_evt > start_evt > counting.
  - stop in any state: go to IDLE. pulse_out and busy drop next cycle. No done.
  - stop and start in the same cycle: stop wins and the start is discarded.
- Start while busy:
  - RETRIG=1: relatch config, clear the pulse counter, restart as from IDLE. pulse_out goes low next cycle if delay > 0.
  - RETRIG=0: start is ignored.
- Arithmetic:
  - Compare counters against value-1 so that the full CNT_W range is usable.
  - Width and period are unsigned.
  - Continuous mode never wraps or asserts done. The pulse counter saturates and is not compared.

## Timing
- Reset values: pulse_out=0, busy=0, done=0, all counters 0, all states IDLE.
- Start sampled at edge T with delay D and width W:
  - pulse_out is high for cycles T+1+D .. T+D+W.
  - The next rising edge is at T+1+D+P (P = effective period).
- Latency start-to-pulse_out is 1 cycle when D=0.
- busy rises at T+1 and falls in the same cycle as the final pulse_out fall.
- done is high for exactly one cycle: the first cycle after the last high cycle, coincident with busy low.
- Stop sampled at edge S: pulse_out=0 and busy=0 from S+1.
- Reset asserted mid-train: outputs go to 0 asynchronously. Channel restarts only on a new start after reset release.

## Test plan
- Ch0: D=0, W=3, P=5, N=2, start at T. Expect pulse_out high at T+1..T+3 and T+6..T+8, done at T+9, busy T+1..T+8.
- Ch1: D=4, W=0, N=1. Expect a single 1-cycle pulse at T+5, done at T+6.
- Ch2: W=4, P=2, N=0 (continuous). Expect 4 high / 1 low repeating. Stop at S gives pulse_out=0 at S+1 and no done. Simultaneous start+stop stays IDLE.
- RETRIG=1: start again mid-HIGH with new D=2. Expect a low gap, then a pulse 3 cycles after the second start, with new cfg used. With RETRIG=0 the same stimulus leaves the train unchanged.
- All 4 channels started on different cycles with different configs. Expect independent, correct waveforms and no crosstalk. Changing cfg_* mid-train does not alter the current train.
- Assert rst during DELAY and HIGH on two channels. Expect all outputs 0 immediately, and no activity until a new start.
